// File: rtl/lrg_arb_pkg.sv
// lrg_arb_pkg: shared FSM state, width helper and triangle-matrix helpers for the LRG arbiter
package lrg_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;
  localparam int MAX_PAIRS = 120;
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
  // Position of pair (i,j), i<j, in the flattened upper triangle
  function automatic int tri_idx(input int i, input int j, input int n);
    return i * (2 * n - i - 1) / 2 + j - i - 1;
  endfunction
  function automatic logic [MAX_PAIRS-1:0] rst_matrix(input int n);
    rst_matrix = '0;
    for (int k = 0; k < n * (n - 1) / 2; k++) rst_matrix[k] = 1'b1;
  endfunction
endpackage

// File: rtl/lrg_matrix_arbiter_if.sv
// lrg_matrix_arbiter_if: requestor/downstream bundle; master drives requests, slave is the arbiter
interface lrg_matrix_arbiter_if #(parameter int NUM_REQ = 4, parameter int NUM_LEVELS = 4);
  import lrg_arb_pkg::*;
  localparam int LEVEL_W = clog2w(NUM_LEVELS);
  localparam int IDX_W = clog2w(NUM_REQ);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*LEVEL_W-1:0] req_level;
  logic [NUM_REQ-1:0] req_last;
  logic ready;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic grant_valid;
  logic timeout;
  modport master(output req, req_level, req_last, ready, input grant, grant_idx, grant_valid, timeout);
  modport slave(input req, req_level, req_last, ready, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/lrg_arb_pick.sv
// lrg_arb_pick: combinational winner among unmasked requests at the highest active level
module lrg_arb_pick
  import lrg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEVEL_W = 2,
  parameter int IDX_W = 2,
  parameter int NUM_PAIRS = 6
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*LEVEL_W-1:0] req_level_i,
  input  logic [NUM_PAIRS-1:0]       prio_i,
  input  logic [NUM_REQ-1:0]         mask_i,
  output logic [NUM_REQ-1:0]         win_o,
  output logic [IDX_W-1:0]           idx_o
);
  logic [NUM_REQ-1:0] act, elig;
  logic [LEVEL_W-1:0] max_lvl;
  always_comb begin
    act = req_i & ~mask_i;
    max_lvl = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (act[i] && req_level_i[i*LEVEL_W +: LEVEL_W] > max_lvl) max_lvl = req_level_i[i*LEVEL_W +: LEVEL_W];
    for (int i = 0; i < NUM_REQ; i++) elig[i] = act[i] && req_level_i[i*LEVEL_W +: LEVEL_W] == max_lvl;
    win_o = elig;
    // Winner must beat every other eligible requestor; lower triangle is the inverse of the stored bit
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = 0; j < NUM_REQ; j++)
        if (j != i && elig[j])
          win_o[i] = win_o[i] & (i < j ? prio_i[tri_idx(i, j, NUM_REQ)] : ~prio_i[tri_idx(j, i, NUM_REQ)]);
    idx_o = '0;
    for (int i = 0; i < NUM_REQ; i++) if (win_o[i]) idx_o = idx_o | IDX_W'(i);
  end
endmodule

// File: rtl/lrg_matrix_arbiter.sv
// lrg_matrix_arbiter: LRG matrix arbiter with priority levels and grant lock until last beat.
// Define LRG_ARB_TIMEOUT_EN to build the MAX_HOLD watchdog that forces a release.
module lrg_matrix_arbiter
  import lrg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_LEVELS = 4,
  parameter int MAX_HOLD = 64
) (
  input logic clk,
  input logic reset,
  lrg_matrix_arbiter_if.slave bus
);
  localparam int LEVEL_W = clog2w(NUM_LEVELS);
  localparam int IDX_W = clog2w(NUM_REQ);
  localparam int NUM_PAIRS = NUM_REQ * (NUM_REQ - 1) / 2;
  localparam logic [NUM_PAIRS-1:0] PRIO_RST = NUM_PAIRS'(rst_matrix(NUM_REQ));
  if (NUM_REQ < 2 || NUM_REQ > 16 || NUM_LEVELS < 2 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("lrg_matrix_arbiter: unsupported parameters");
  end
  arb_state_e state_q, state_d;
  logic [NUM_PAIRS-1:0] prio_q, prio_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, win;
  logic [IDX_W-1:0] idx_q, idx_d, widx;
  logic valid_q, normal_rel, force_rel, release_w, load;
  assign normal_rel = state_q == ARB_HOLD && bus.ready && |(bus.req_last & grant_q);
`ifdef LRG_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2w(MAX_HOLD + 1);
  logic [CNT_W-1:0] cnt_q;
  logic tmo_q;
  assign force_rel = state_q == ARB_HOLD && !normal_rel && cnt_q == CNT_W'(MAX_HOLD);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= (load || state_q == ARB_IDLE) ? '0 : cnt_q + 1'b1;
      tmo_q <= force_rel;
    end
  assign bus.timeout = tmo_q;
`else
  assign force_rel = 1'b0;
  assign bus.timeout = 1'b0;
`endif
  assign release_w = normal_rel || force_rel;
  lrg_arb_pick #(.NUM_REQ(NUM_REQ), .LEVEL_W(LEVEL_W), .IDX_W(IDX_W), .NUM_PAIRS(NUM_PAIRS)) u_pick (
    .req_i(bus.req), .req_level_i(bus.req_level), .prio_i(prio_d), .mask_i(grant_q), .win_o(win), .idx_o(widx)
  );
  // Releasing holder drops to lowest priority; re-arbitration sees the updated matrix the same cycle
  always_comb begin
    prio_d = prio_q;
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = i + 1; j < NUM_REQ; j++)
        if (release_w)
          prio_d[tri_idx(i, j, NUM_REQ)] = grant_q[j] ? 1'b1 : grant_q[i] ? 1'b0 : prio_q[tri_idx(i, j, NUM_REQ)];
    load = state_q == ARB_IDLE ? |bus.req : release_w;
    grant_d = load ? win : grant_q;
    idx_d = load ? widx : idx_q;
    state_d = load ? (|win ? ARB_HOLD : ARB_IDLE) : state_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ARB_IDLE;
      prio_q <= PRIO_RST;
      grant_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      valid_q <= |grant_d;
    end
  assign bus.grant = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.grant_valid = valid_q;
endmodule

// File: tb/tb_lrg_matrix_arbiter.sv
// tb_lrg_matrix_arbiter: directed vector table, reset/timeout sequences and random LRG traffic
module tb_lrg_matrix_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int k_rel = 0;
  lrg_matrix_arbiter_if #(.NUM_REQ(4), .NUM_LEVELS(4)) bus ();
  lrg_matrix_arbiter #(.NUM_REQ(4), .NUM_LEVELS(4), .MAX_HOLD(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] req;
    logic [7:0] lvl;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] g;
    logic [1:0] idx;
  } vec_t;
  vec_t tv [22];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic [3:0] r, input logic [7:0] l, input logic [3:0] la, input logic rd);
    bus.req = r;
    bus.req_level = l;
    bus.req_last = la;
    bus.ready = rd;
  endtask
  function automatic logic [1:0] enc(input logic [3:0] g);
    enc = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) enc = 2'(i);
  endfunction
  logic [3:0] pend, prev_g, prev_req, prev_last, g;
  logic prev_rdy, rel;
  int wait_cnt [4];
  initial begin
    drive(4'h0, 8'h00, 4'h0, 1'b0);
    // Equal-level round robin, level priority, 4-beat stalled transfer, lock despite req drop, mixed levels
    tv[0]  = '{4'hF, 8'h00, 4'hF, 1'b1, 4'b0001, 2'd0};
    tv[1]  = '{4'hF, 8'h00, 4'hF, 1'b1, 4'b0010, 2'd1};
    tv[2]  = '{4'hF, 8'h00, 4'hF, 1'b1, 4'b0100, 2'd2};
    tv[3]  = '{4'hF, 8'h00, 4'hF, 1'b1, 4'b1000, 2'd3};
    tv[4]  = '{4'hF, 8'h00, 4'hF, 1'b1, 4'b0001, 2'd0};
    tv[5]  = '{4'h6, 8'h30, 4'h1, 1'b1, 4'b0100, 2'd2};
    tv[6]  = '{4'h6, 8'h30, 4'h0, 1'b1, 4'b0100, 2'd2};
    tv[7]  = '{4'h2, 8'h30, 4'h4, 1'b1, 4'b0010, 2'd1};
    tv[8]  = '{4'h3, 8'h00, 4'h0, 1'b1, 4'b0010, 2'd1};
    tv[9]  = '{4'h3, 8'h00, 4'h0, 1'b0, 4'b0010, 2'd1};
    tv[10] = '{4'h3, 8'h00, 4'h0, 1'b1, 4'b0010, 2'd1};
    tv[11] = '{4'h3, 8'h00, 4'h0, 1'b1, 4'b0010, 2'd1};
    tv[12] = '{4'h3, 8'h00, 4'h2, 1'b1, 4'b0001, 2'd0};
    tv[13] = '{4'h0, 8'h00, 4'h0, 1'b1, 4'b0001, 2'd0};
    tv[14] = '{4'h8, 8'h00, 4'h0, 1'b1, 4'b0001, 2'd0};
    tv[15] = '{4'h8, 8'h00, 4'h1, 1'b1, 4'b1000, 2'd3};
    tv[16] = '{4'h0, 8'h00, 4'h8, 1'b1, 4'b0000, 2'd0};
    tv[17] = '{4'h0, 8'h00, 4'h0, 1'b1, 4'b0000, 2'd0};
    tv[18] = '{4'hF, 8'h29, 4'hF, 1'b1, 4'b0100, 2'd2};
    tv[19] = '{4'hF, 8'h29, 4'hF, 1'b1, 4'b0010, 2'd1};
    tv[20] = '{4'hF, 8'h29, 4'hF, 1'b1, 4'b0100, 2'd2};
    tv[21] = '{4'hF, 8'h29, 4'hF, 1'b0, 4'b0100, 2'd2};
    #12;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_idx", 32'(bus.grant_idx), 0);
    chk("rst_valid", 32'(bus.grant_valid), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 22; k++) begin
      drive(tv[k].req, tv[k].lvl, tv[k].last, tv[k].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_grant", k), 32'(bus.grant), 32'(tv[k].g));
      chk($sformatf("vec%0d_idx", k), 32'(bus.grant_idx), 32'(tv[k].idx));
      chk($sformatf("vec%0d_valid", k), 32'(bus.grant_valid), 32'(|tv[k].g));
      chk($sformatf("vec%0d_timeout", k), 32'(bus.timeout), 0);
    end
    #2 reset = 1'b1;
    #1;
    chk("midhold_rst_grant", 32'(bus.grant), 0);
    chk("midhold_rst_valid", 32'(bus.grant_valid), 0);
    @(negedge clk) reset = 1'b0;
    drive(4'b1100, 8'h00, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("after_rst_grant", 32'(bus.grant), 32'h4);
    chk("after_rst_idx", 32'(bus.grant_idx), 2);
    drive(4'b1100, 8'h00, 4'h0, 1'b1);
`ifdef LRG_ARB_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.grant !== 4'b0100) begin
        k_rel = k;
        break;
      end
    end
    chk("tmo_cycle", 32'(k_rel), 9);
    chk("tmo_grant", 32'(bus.grant), 32'h8);
    chk("tmo_pulse", 32'(bus.timeout), 1);
    @(posedge clk);
    #1;
    chk("tmo_end", 32'(bus.timeout), 0);
`else
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk("hold_no_tmo_grant", 32'(bus.grant), 32'h4);
      chk("hold_no_tmo_pulse", 32'(bus.timeout), 0);
    end
`endif
    reset = 1'b1;
    drive(4'h0, 8'h00, 4'h0, 1'b0);
    @(negedge clk) reset = 1'b0;
    pend = '0;
    prev_g = '0;
    prev_req = '0;
    prev_last = '0;
    prev_rdy = 1'b0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      g = bus.grant;
      rel = prev_g != 0 && ((prev_rdy && |(prev_last & prev_g)) || bus.timeout);
      chk("rnd_onehot", 32'($onehot0(g)), 1);
      chk("rnd_valid", 32'(bus.grant_valid), 32'(|g));
      chk("rnd_idx", 32'(bus.grant_idx), 32'(enc(g)));
      if (prev_g != 0 && !rel) chk("rnd_lock", 32'(g), 32'(prev_g));
      if (rel) chk("rnd_holder_masked", 32'(g & prev_g), 0);
      for (int i = 0; i < 4; i++) begin
        if (rel && prev_req[i] && !prev_g[i]) wait_cnt[i]++;
        if (g[i] && g != prev_g) begin
          chk($sformatf("rnd_starve%0d", i), 32'(wait_cnt[i] <= 3), 1);
          wait_cnt[i] = 0;
        end
      end
      if (rel) pend = pend & ~prev_g;
      for (int i = 0; i < 4; i++) if (!pend[i] && $urandom_range(0, 3) == 0) pend[i] = 1'b1;
      drive(pend, 8'h00, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      prev_req = bus.req;
      prev_last = bus.req_last;
      prev_rdy = bus.ready;
      prev_g = g;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
